// File: rtl/ascon_pkg.sv
// Shared types, round constants and the word-level round helpers for the Ascon permutation.
// The state is x0..x4, with x0 in the most significant 64 bits of the packed struct.
package ascon_pkg;

  typedef struct packed {
    logic [63:0] x0;
    logic [63:0] x1;
    logic [63:0] x2;
    logic [63:0] x3;
    logic [63:0] x4;
  } ascon_state_t;

  typedef enum logic [1:0] {StIdle, StRun, StDone} perm_state_e;

  localparam int unsigned MAX_ROUNDS = 16;

  // Element [i] is C[i]; element [0] sits rightmost.
  localparam logic [15:0][7:0] ROUND_CONST = {
    8'h4b, 8'h5a, 8'h69, 8'h78, 8'h87, 8'h96, 8'ha5, 8'hb4,
    8'hc3, 8'hd2, 8'he1, 8'hf0, 8'h0f, 8'h1e, 8'h2d, 8'h3c
  };

  function automatic logic [63:0] rotr64(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic ascon_state_t ascon_linear(input ascon_state_t s);
    ascon_state_t o;
    o.x0 = s.x0 ^ rotr64(s.x0, 19) ^ rotr64(s.x0, 28);
    o.x1 = s.x1 ^ rotr64(s.x1, 61) ^ rotr64(s.x1, 39);
    o.x2 = s.x2 ^ rotr64(s.x2, 1) ^ rotr64(s.x2, 6);
    o.x3 = s.x3 ^ rotr64(s.x3, 10) ^ rotr64(s.x3, 17);
    o.x4 = s.x4 ^ rotr64(s.x4, 7) ^ rotr64(s.x4, 41);
    return o;
  endfunction

  function automatic ascon_state_t ascon_const_add(input ascon_state_t s, input logic [7:0] c);
    ascon_state_t o;
    o = s;
    o.x2 = s.x2 ^ {56'b0, c};
    return o;
  endfunction

endpackage

// File: rtl/ascon_round.sv
// One combinational Ascon round: constant addition, S-box layer, linear diffusion.
module ascon_round
  import ascon_pkg::*;
(
  input  ascon_state_t state_i,
  input  logic [7:0]   const_i,
  output ascon_state_t state_o
);

  ascon_state_t w_added;
  ascon_state_t w_sbox;

  assign w_added = ascon_const_add(state_i, const_i);

  substitution_layer u_sbox (
    .state_i (w_added),
    .state_o (w_sbox)
  );

  assign state_o = ascon_linear(w_sbox);

endmodule

// File: rtl/substitution_layer.sv
// Bit-sliced Ascon 5-bit S-box applied in parallel to all 64 slices of the state.
module substitution_layer
  import ascon_pkg::*;
(
  input  ascon_state_t state_i,
  output ascon_state_t state_o
);

  logic [63:0] w_a0, w_a2, w_a4;
  logic [63:0] w_b0, w_b1, w_b2, w_b3, w_b4;

  assign w_a0 = state_i.x0 ^ state_i.x4;
  assign w_a4 = state_i.x4 ^ state_i.x3;
  assign w_a2 = state_i.x2 ^ state_i.x1;

  // Chi-like core: each word absorbs (~next & next-next) of its neighbours.
  assign w_b0 = w_a0 ^ (~state_i.x1 & w_a2);
  assign w_b1 = state_i.x1 ^ (~w_a2 & state_i.x3);
  assign w_b2 = w_a2 ^ (~state_i.x3 & w_a4);
  assign w_b3 = state_i.x3 ^ (~w_a4 & w_a0);
  assign w_b4 = w_a4 ^ (~w_a0 & state_i.x1);

  assign state_o.x0 = w_b0 ^ w_b4;
  assign state_o.x1 = w_b1 ^ w_b0;
  assign state_o.x2 = ~w_b2;
  assign state_o.x3 = w_b3 ^ w_b2;
  assign state_o.x4 = w_b4;

endmodule

// File: rtl/ascon_permutation.sv
// Iterative Ascon-p[rnd] engine: 0..16 rounds on a 320-bit state, UNROLL (1 or 2) rounds/clock.
// idx counts up from 16-r to 16 and selects the round constant directly.
module ascon_permutation
  import ascon_pkg::*;
#(
  parameter int unsigned UNROLL = 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         start_i,
  input  logic [4:0]   rounds_i,
  input  ascon_state_t state_i,
  output logic         ready_o,
  output logic         busy_o,
  output logic         done_o,
  output ascon_state_t state_o
);

  perm_state_e  r_fsm;
  ascon_state_t r_state;
  logic [4:0]   r_idx;
  logic         r_ready, r_busy, r_done;

  ascon_state_t w_round0;
  ascon_state_t w_next;
  logic [4:0]   w_step;
  logic [4:0]   w_idx_next;
  logic [4:0]   w_rounds_eff;
  logic [4:0]   w_idx_load;

  assign w_rounds_eff = (rounds_i > 5'(MAX_ROUNDS)) ? 5'(MAX_ROUNDS) : rounds_i;
  assign w_idx_load   = 5'(MAX_ROUNDS) - w_rounds_eff;

  ascon_round u_round0 (
    .state_i (r_state),
    .const_i (ROUND_CONST[r_idx[3:0]]),
    .state_o (w_round0)
  );

  generate
    if (UNROLL == 2) begin : g_unroll2
      logic         w_one_left;
      ascon_state_t w_round1;

      assign w_one_left = (r_idx == 5'd15);

      ascon_round u_round1 (
        .state_i (w_round0),
        .const_i (ROUND_CONST[r_idx[3:0] + 4'd1]),
        .state_o (w_round1)
      );

      // Odd round counts finish with the second instance bypassed.
      assign w_next = w_one_left ? w_round0 : w_round1;
      assign w_step = w_one_left ? 5'd1 : 5'd2;
    end else begin : g_unroll1
      assign w_next = w_round0;
      assign w_step = 5'd1;
    end
  endgenerate

  assign w_idx_next = r_idx + w_step;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_fsm   <= StIdle;
      r_state <= '0;
      r_idx   <= 5'(MAX_ROUNDS);
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_fsm)
        StIdle, StDone: begin
          if (start_i) begin
            r_state <= state_i;
            r_idx   <= w_idx_load;
            r_fsm   <= (w_rounds_eff == 5'd0) ? StDone : StRun;
            r_ready <= (w_rounds_eff == 5'd0);
            r_busy  <= (w_rounds_eff != 5'd0);
            r_done  <= (w_rounds_eff == 5'd0);
          end else begin
            r_fsm   <= StIdle;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
          end
        end
        StRun: begin
          r_state <= w_next;
          r_idx   <= w_idx_next;
          if (w_idx_next == 5'(MAX_ROUNDS)) begin
            r_fsm   <= StDone;
            r_ready <= 1'b1;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: begin
          r_fsm   <= StIdle;
          r_ready <= 1'b1;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign ready_o = r_ready;
  assign busy_o  = r_busy;
  assign done_o  = r_done;
  assign state_o = r_state;

endmodule

// File: doc/ascon_permutation.md
# ascon_permutation

Iterative Ascon-p[rnd] permutation engine (NIST SP 800-232) that wraps the bit-sliced `substitution_layer`. It runs 1 to 16 rounds on a 320-bit state, applying UNROLL rounds per clock. Each round is constant addition, then the S-box layer, then linear diffusion. The block sits between the mode controllers (AEAD, hash, XOF) and the round datapath, and is their only path into the permutation.

## Interface
- `UNROLL`, default 1: rounds computed per clock; legal values are 1 and 2.
- `clk_i` input, 1: single clock. Synchronous active-high reset; all flops update on the rising edge only.
- `rst_i` input, 1: reset, synchronous, active-high.
- `start_i` input, 1: request a permutation. Accepted only when `start_i && ready_o`.
- `rounds_i` input, 5: round count. Range 0..16; values above 16 are clamped to 16. Sampled at accept.
- `state_i` input, `ascon_pkg::ascon_state_t`: input state, sampled at accept.
- `ready_o` output, 1: high when able to accept a request (IDLE or DONE).
- `busy_o` output, 1: high in RUN.
- `done_o` output, 1: one-cycle pulse; `state_o` holds the result in this cycle.
- `state_o` output, `ascon_pkg::ascon_state_t`: the state register, driven directly. Valid when `done_o` is high, and held until the next accept.

## Operation
- FSM states are IDLE, RUN and DONE.
- **Accept** (IDLE or DONE with `start_i`):
  - load `state_i` into the state register;
  - compute the effective count r = min(`rounds_i`, 16);
  - load the constant index `idx` (5 bits) = 16 − r;
  - go to RUN if r > 0, otherwise go to DONE.
- **RUN edge:** apply k = min(UNROLL, 16 − idx) rounds, then set idx += k. If idx reaches 16, go to DONE; otherwise stay in RUN.
- **DONE:** `done_o` = 1 for exactly one cycle. Next state is RUN or DONE if a new request is accepted in this cycle, otherwise IDLE.
- **Start while busy:** `start_i` in RUN is ignored with no side effect. The requester must hold the request until `ready_o`.
- **One round at constant index i:**
  - constant addition: x2 ^= {56'b0, C[i]};
  - S-box: `substitution_layer` on all 64 bit-slices;
  - linear layer (right rotations):
    - x0 ^= (x0 ⋙ 19) ^ (x0 ⋙ 28)
    - x1 ^= (x1 ⋙ 61) ^ (x1 ⋙ 39)
    - x2 ^= (x2 ⋙ 1) ^ (x2 ⋙ 6)
    - x3 ^= (x3 ⋙ 10) ^ (x3 ⋙ 17)
    - x4 ^= (x4 ⋙ 7) ^ (x4 ⋙ 41)
- **Round constants C[0..15]:** 3c 2d 1e 0f f0 e1 d2 c3 b4 a5 96 87 78 69 5a 4b. p[12] therefore starts at C[4] = f0, p[8] at C[8] = b4, and p[6] at C[10] = 96.
- **UNROLL=2 datapath:** two round instances in series, using constants C[idx] and C[idx+1]. When only one round remains (odd r), the second instance is bypassed combinationally.
- **Reset:**
  - takes effect at the next edge, including mid-RUN; the in-flight permutation is discarded and no `done_o` is issued;
  - FSM → IDLE, state register → 0, idx → 16;
  - outputs: `ready_o`=1, `busy_o`=0, `done_o`=0, `state_o`=0.

## Timing
- **Accept edge:** call it E0.
- **RUN length:** ceil(r/UNROLL) cycles.
- **`done_o` cycle:** the cycle after edge E0 + ceil(r/UNROLL).
  - Example, r=12 with UNROLL=1: `done_o` in cycle 13 after accept.
  - Example, r=12 with UNROLL=2: cycle 7.
  - Example, r=0: cycle 1, with `state_o` = `state_i`.
- **Back-to-back:** an accept in the DONE cycle gives zero idle cycles. `ready_o` and `done_o` are both high that cycle.
- **Critical path:** one round (UNROLL=1) or two rounds (UNROLL=2) from register to register. There is no combinational path from inputs to outputs.

## Structure
- **Additions to `ascon_pkg`:**
  - `ROUND_CONST` as a 16×8 constant;
  - `MAX_ROUNDS` = 16;
  - function `ascon_linear(ascon_state_t)`;
  - function `ascon_const_add(ascon_state_t, logic [7:0])`.
- **Sub-module:** `ascon_round`, combinational. Inputs are the state and an 8-bit constant; it instantiates `substitution_layer`. `ascon_permutation` instantiates UNROLL copies plus the FSM, counter and state register.

## Test plan
- **p[12] on zero state, UNROLL=1:**
  - stimulus: reset, then `state_i`=0, `rounds_i`=12, one-cycle `start_i`;
  - required: `busy_o` high for 12 cycles, `done_o` in cycle 13, `state_o` equals the golden C model of Ascon-p[12];
  - repeat with the IV 0x00001000808c0001 in x0.
- **One-round check:**
  - stimulus: `rounds_i`=1, zero state;
  - required: the post-S-box intermediate (probed) has x0=x1=x3=0x4b, x2=0xffffffffffffffb4, x4=0. Final `state_o` matches the model, and `done_o` is in cycle 2.
- **Boundary counts:**
  - `rounds_i`=0 gives `done_o` in cycle 1 with `state_o`=`state_i`;
  - `rounds_i`=16 uses C[0..15];
  - `rounds_i`=31 behaves identically to 16.
- **Back-to-back and ignored start:**
  - stimulus: accept p[8] in the DONE cycle of a p[12]; pulse `start_i` mid-RUN;
  - required: the second result is correct with no idle cycle, and the mid-RUN start causes no change.
- **Reset mid-RUN:**
  - stimulus: assert `rst_i` at RUN cycle 5;
  - required: the next cycle has `state_o`=0, `ready_o`=1, and no `done_o`; a subsequent p[12] is correct.
- **UNROLL=2 regression:**
  - stimulus: r = 12, 6, 1, 7 in random order against the model;
  - required: `done_o` at cycles 7, 4, 2 and 5 respectively.
